// File: rtl/seq_pkg.sv
// Shared types and constants for the digit step sequencer.
package seq_pkg;

   // Width of the datapath digit bus and the default legal digit range.
   localparam int                   DIGIT_W       = 3;
   localparam logic [DIGIT_W-1:0]   MIN_DIGIT_DEF = 3'd1;
   localparam logic [DIGIT_W-1:0]   MAX_DIGIT_DEF = 3'd5;

   // Step-source selection state.
   typedef enum logic [1:0] {
      MANUAL     = 2'b00,
      AUTO_RUN   = 2'b01,
      AUTO_PAUSE = 2'b10
   } seq_state_t;

   // True when a digit lies inside the inclusive range [lo, hi].
   function automatic logic digit_legal(input logic [DIGIT_W-1:0] d,
                                        input logic [DIGIT_W-1:0] lo,
                                        input logic [DIGIT_W-1:0] hi);
      return (d >= lo) && (d <= hi);
   endfunction

endpackage : seq_pkg

// File: rtl/btn_debounce.sv
// Conditions the raw active-low step button: two-flop synchronizer,
// stable-count debouncer and a one-cycle pulse on each debounced press.
module btn_debounce #(
   parameter int DEBOUNCE_CYC = 16
) (
   input  logic clk,
   input  logic reset_n,
   input  logic raw_n,
   output logic press_pulse
);

   localparam int               CNT_W    = $clog2(DEBOUNCE_CYC + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

   logic             sync1;
   logic             sync2;
   logic             level;
   logic             level_d;
   logic [CNT_W-1:0] stable_cnt;

   // Bring the asynchronous button into the clock domain; idle level is released (1).
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values; blocking here would collapse the two stages.
      if (!reset_n) begin
         sync1 <= 1'b1;
         sync2 <= 1'b1;
      end else begin
         sync1 <= raw_n;
         sync2 <= sync1;
      end
   end

   // Accept a new level only after it has differed for DEBOUNCE_CYC consecutive cycles.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         level      <= 1'b1;
         stable_cnt <= '0;
      end else if (sync2 != level) begin
         if (stable_cnt == CNT_LAST) begin
            level      <= sync2;
            stable_cnt <= '0;
         end else begin
            stable_cnt <= stable_cnt + 1'b1;
         end
      end else begin
         stable_cnt <= '0;
      end
   end

   // Registered falling-edge detect of the debounced level: one pulse per press.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         level_d     <= 1'b1;
         press_pulse <= 1'b0;
      end else begin
         level_d     <= level;
         press_pulse <= level_d & ~level;
      end
   end

endmodule : btn_debounce

// File: rtl/step_sequencer_ctrl.sv
// Step sequencer controller: arbitrates manual presses and auto-step ticks,
// tracks the effective direction (with optional ping-pong reversal at the
// range ends) and issues one-cycle step commands to the digit datapath.
module step_sequencer_ctrl
   import seq_pkg::*;
#(
   parameter int                 TICK_DIV     = 50000000,
   parameter int                 DEBOUNCE_CYC = 16,
   parameter logic [DIGIT_W-1:0] MIN_DIGIT    = MIN_DIGIT_DEF,
   parameter logic [DIGIT_W-1:0] MAX_DIGIT    = MAX_DIGIT_DEF
) (
   input  logic               clk,
   input  logic               reset_n,
   input  logic               btn_step_n,
   input  logic               mode_auto,
   input  logic               dir_sw,
   input  logic               pingpong,
   input  logic               pause,
   input  logic [DIGIT_W-1:0] cur_digit,
   output logic               step,
   output logic               step_fwd,
   output logic               dir_state,
   output logic               auto_active,
   output logic               err
);

   localparam int                TICK_W    = $clog2(TICK_DIV);
   localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

   seq_state_t        state;
   seq_state_t        state_next;
   logic [TICK_W-1:0] tick_cnt;
   logic              press;
   logic              tick;
   logic              want_step;
   logic              fire;
   logic              at_end;
   logic              issued_fwd;

   btn_debounce #(
      .DEBOUNCE_CYC (DEBOUNCE_CYC)
   ) u_btn (
      .clk         (clk),
      .reset_n     (reset_n),
      .raw_n       (btn_step_n),
      .press_pulse (press)
   );

   // Next step-source state; leaving auto mode outranks pause.
   always_comb begin
      // NOTE: default first so every path assigns state_next and no latch is inferred.
      state_next = state;
      case (state)
         MANUAL: begin
            if (mode_auto) state_next = AUTO_RUN;
         end
         AUTO_RUN: begin
            if (!mode_auto)  state_next = MANUAL;
            else if (pause)  state_next = AUTO_PAUSE;
         end
         AUTO_PAUSE: begin
            if (!mode_auto)  state_next = MANUAL;
            else if (!pause) state_next = AUTO_RUN;
         end
         default: state_next = MANUAL;
      endcase
   end

   // Pick the step source for the current state and work out the issued direction.
   always_comb begin
      tick      = (state == AUTO_RUN) && (tick_cnt == TICK_LAST);
      want_step = 1'b0;
      case (state)
         MANUAL, AUTO_PAUSE: want_step = press;
         AUTO_RUN:           want_step = tick;
         default:            want_step = 1'b0;
      endcase
      fire       = want_step & ~err;
      at_end     = dir_state ? (cur_digit == MAX_DIGIT) : (cur_digit == MIN_DIGIT);
      issued_fwd = (pingpong && at_end) ? ~dir_state : dir_state;
   end

   // State register.
   always_ff @(posedge clk) begin
      if (!reset_n) state <= MANUAL;
      else          state <= state_next;
   end

   // Auto-step divider: restarts from zero around MANUAL, runs in AUTO_RUN, holds when paused.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         tick_cnt <= '0;
      end else if ((state == MANUAL) || (state_next == MANUAL)) begin
         tick_cnt <= '0;
      end else if (state == AUTO_RUN) begin
         tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
      end
   end

   // Registered step command, issued direction, run indicator and sticky error.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         step        <= 1'b0;
         step_fwd    <= 1'b1;
         auto_active <= 1'b0;
         err         <= 1'b0;
      end else begin
         step        <= fire;
         if (fire) step_fwd <= issued_fwd;
         auto_active <= (state_next == AUTO_RUN);
         err         <= err | ~digit_legal(cur_digit, MIN_DIGIT, MAX_DIGIT);
      end
   end

   // Effective direction: follows the switch, or bounces at the range ends in ping-pong mode.
   always_ff @(posedge clk) begin
      if (!reset_n)       dir_state <= 1'b1;
      else if (!pingpong) dir_state <= dir_sw;
      else if (fire)      dir_state <= issued_fwd;
   end

endmodule : step_sequencer_ctrl

// File: tb/tb_step_sequencer_ctrl.sv
// Self-checking bench for step_sequencer_ctrl with TICK_DIV=4, DEBOUNCE_CYC=2.
module tb_step_sequencer_ctrl;

   localparam int         TD    = 4;
   localparam int         DB    = 2;
   localparam logic [2:0] MIN_D = 3'd1;
   localparam logic [2:0] MAX_D = 3'd5;

   logic       clk = 1'b0;
   logic       reset_n;
   logic       btn_step_n;
   logic       mode_auto;
   logic       dir_sw;
   logic       pingpong;
   logic       pause;
   logic [2:0] cur_digit;
   logic       step;
   logic       step_fwd;
   logic       dir_state;
   logic       auto_active;
   logic       err;

   always #5 clk = ~clk;

   step_sequencer_ctrl #(
      .TICK_DIV     (TD),
      .DEBOUNCE_CYC (DB),
      .MIN_DIGIT    (MIN_D),
      .MAX_DIGIT    (MAX_D)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .btn_step_n  (btn_step_n),
      .mode_auto   (mode_auto),
      .dir_sw      (dir_sw),
      .pingpong    (pingpong),
      .pause       (pause),
      .cur_digit   (cur_digit),
      .step        (step),
      .step_fwd    (step_fwd),
      .dir_state   (dir_state),
      .auto_active (auto_active),
      .err         (err)
   );

   int n_vec = 0;
   int n_bad = 0;
   bit cmp_en = 1'b0;

   task automatic check(input string name, input logic act, input logic exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural reference: modes as plain labels, the button as a sample queue
   // plus a run length, the press time remembered as a cycle number.
   typedef enum {M_MAN, M_RUN, M_PAUSE} mmode_t;
   mmode_t m_mode;
   int     m_cnt;
   bit     m_step, m_fwd, m_dir, m_active, m_err;
   bit     m_syncq[$];
   bit     m_lvl;
   int     m_run;
   int     m_cyc = 0;
   int     m_fall_cyc;

   task automatic model_edge();
      bit     press, want, fire, inv, issued, obs;
      mmode_t nm;
      m_cyc++;
      if (!reset_n) begin
         m_mode = M_MAN; m_cnt = 0; m_step = 0; m_fwd = 1; m_dir = 1;
         m_active = 0; m_err = 0; m_syncq = '{1'b1, 1'b1}; m_lvl = 1;
         m_run = 0; m_fall_cyc = -100;
         return;
      end
      // A debounced fall becomes a step two edges later.
      press  = (m_fall_cyc == m_cyc - 2);
      want   = (m_mode == M_RUN) ? (m_cnt == TD - 1) : press;
      fire   = want && !m_err;
      inv    = pingpong && (m_dir ? (cur_digit == MAX_D) : (cur_digit == MIN_D));
      issued = inv ? !m_dir : m_dir;
      m_step = fire;
      if (fire) m_fwd = issued;
      m_dir  = pingpong ? (fire ? issued : m_dir) : dir_sw;
      if (cur_digit < MIN_D || cur_digit > MAX_D) m_err = 1;
      if (!mode_auto)          nm = M_MAN;
      else if (m_mode == M_MAN) nm = M_RUN;
      else                     nm = pause ? M_PAUSE : M_RUN;
      if (nm == M_MAN || m_mode == M_MAN) m_cnt = 0;
      else if (m_mode == M_RUN)           m_cnt = (m_cnt + 1) % TD;
      m_active = (nm == M_RUN);
      m_mode   = nm;
      obs = m_syncq.pop_front();
      m_syncq.push_back(btn_step_n);
      if (obs != m_lvl) begin
         m_run++;
         if (m_run == DB) begin
            m_lvl = obs;
            m_run = 0;
            if (!obs) m_fall_cyc = m_cyc;
         end
      end else begin
         m_run = 0;
      end
   endtask

   always @(posedge clk) model_edge();

   // Compare DUT against the model away from the active edge.
   always @(negedge clk) begin
      if (cmp_en) begin
         check("step", step, m_step);
         if (m_step) check("step_fwd", step_fwd, m_fwd);
         check("dir_state", dir_state, m_dir);
         check("auto_active", auto_active, m_active);
         check("err", err, m_err);
      end
   end

   task automatic tick_n(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Press for 10 cycles: exactly one step, 5 edges after the first low sample.
   task automatic press_check(input logic exp_fwd, input logic exp_dir);
      btn_step_n = 1'b0;
      for (int i = 1; i <= 10; i++) begin
         @(negedge clk);
         check("press_step", step, i == 6);
         if (i == 6) begin
            check("press_fwd", step_fwd, exp_fwd);
            check("press_dir", dir_state, exp_dir);
         end
      end
      btn_step_n = 1'b1;
      tick_n(8);
   endtask

   initial begin
      int hold;
      int r;
      reset_n = 0; btn_step_n = 1; mode_auto = 0; dir_sw = 1;
      pingpong = 0; pause = 0; cur_digit = 3'd1;
      @(negedge clk);
      cmp_en = 1'b1;
      // Reset with inputs toggled.
      btn_step_n = 0; mode_auto = 1; dir_sw = 0; pingpong = 1; pause = 1; cur_digit = 3'd0;
      @(negedge clk);
      check("rst_step", step, 1'b0);
      check("rst_fwd", step_fwd, 1'b1);
      check("rst_dir", dir_state, 1'b1);
      check("rst_active", auto_active, 1'b0);
      check("rst_err", err, 1'b0);
      btn_step_n = 1; mode_auto = 0; dir_sw = 1; pingpong = 0; pause = 0; cur_digit = 3'd1;
      reset_n = 1;
      tick_n(4);

      // Manual presses, glitch rejection, backward direction.
      press_check(1'b1, 1'b1);
      btn_step_n = 0;
      @(negedge clk);
      btn_step_n = 1;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         check("glitch_nostep", step, 1'b0);
      end
      dir_sw = 0;
      tick_n(2);
      press_check(1'b0, 1'b0);
      dir_sw = 1;
      tick_n(2);

      // Auto run: a step every 4 cycles, first one 4 cycles after entry.
      mode_auto = 1;
      for (int i = 1; i <= 12; i++) begin
         @(negedge clk);
         check("auto_active_run", auto_active, 1'b1);
         check("auto_step", step, (i >= 5) && (i % 4 == 1));
      end
      pause = 1;
      tick_n(2);
      check("pause_inactive", auto_active, 1'b0);
      press_check(1'b1, 1'b1);
      pause = 0;
      tick_n(12);
      mode_auto = 0;
      tick_n(3);
      check("manual_inactive", auto_active, 1'b0);

      // Ping-pong reversal at both ends, none in the middle.
      pingpong  = 1;
      cur_digit = 3'd5;
      tick_n(1);
      press_check(1'b0, 1'b0);
      cur_digit = 3'd1;
      press_check(1'b1, 1'b1);
      cur_digit = 3'd3;
      press_check(1'b1, 1'b1);
      pingpong = 0;
      dir_sw   = 0;
      tick_n(2);
      check("pp_reload", dir_state, 1'b0);
      dir_sw = 1;
      tick_n(1);

      // Illegal digit: sticky err, steps suppressed until reset.
      cur_digit = 3'd0;
      @(negedge clk);
      cur_digit = 3'd3;
      check("err_set", err, 1'b1);
      mode_auto  = 1;
      btn_step_n = 0;
      for (int i = 0; i < 12; i++) begin
         @(negedge clk);
         check("err_nostep", step, 1'b0);
      end
      btn_step_n = 1;
      mode_auto  = 0;
      tick_n(2);
      reset_n = 0;
      @(negedge clk);
      check("err_clear", err, 1'b0);
      reset_n = 1;
      tick_n(2);

      // Reset in AUTO_RUN with the divider at 3: pending tick aborted.
      mode_auto = 1;
      tick_n(4);
      reset_n = 0;
      @(negedge clk);
      check("midrst_nostep", step, 1'b0);
      check("midrst_inactive", auto_active, 1'b0);
      reset_n = 1;
      for (int i = 1; i <= 6; i++) begin
         @(negedge clk);
         check("rerun_step", step, i == 5);
      end
      mode_auto = 0;
      tick_n(2);

      // Randomized traffic against the model.
      hold = 0;
      for (int c = 0; c < 4000; c++) begin
         @(negedge clk);
         if (hold == 0) begin
            btn_step_n = 1'($urandom_range(0, 1));
            hold       = int'($urandom_range(1, 12));
         end else begin
            hold--;
         end
         if ($urandom_range(0, 59) == 0) mode_auto = ~mode_auto;
         if ($urandom_range(0, 19) == 0) pause     = ~pause;
         if ($urandom_range(0, 79) == 0) pingpong  = ~pingpong;
         if ($urandom_range(0, 14) == 0) dir_sw    = ~dir_sw;
         if ($urandom_range(0, 2) == 0)  cur_digit = 3'($urandom_range(1, 5));
         if ($urandom_range(0, 599) == 0) begin
            r = int'($urandom_range(0, 2));
            cur_digit = (r == 0) ? 3'd0 : ((r == 1) ? 3'd6 : 3'd7);
         end
         reset_n = ($urandom_range(0, 299) != 0);
      end
      reset_n = 1;
      tick_n(2);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule : tb_step_sequencer_ctrl
